neuron_decay_scheduler: RTL and testbench
=========================================

// Module: neuron_decay_scheduler
// PURPOSE
//  Per-timestep sequencer for the shared potential-decay datapath (IEEE-754 single, exponent-shift decay).
//  On each timestep pulse it walks neurons 0..NUM_NEURONS-1 through four steps per neuron:
//   read potential from membrane memory -> issue to decay unit -> collect result -> write back.
//  Holds the per-neuron decay_rate/model configuration table that the decay unit previously had hardwired.
// PARAMETERS
//  NUM_NEURONS  20  neurons swept per timestep (1..4096)
//  ADDR_W       12  neuron address width
//  DATA_W       32  membrane potential width (IEEE-754 single)
// PORTS
//  clk                 in   1       single clock, all logic on posedge
//  rst                 in   1       synchronous, active-high reset
//  timestep_start      in   1       1-cycle pulse: begin decay sweep
//  cfg_we              in   1       config table write strobe
//  cfg_addr            in   ADDR_W  neuron to configure
//  cfg_decay_rate      in   4       0001 /1, 0010 /2, 0100 /4, 1000 /8, 0011 /2+/4
//  cfg_model           in   2       00 LIF (others reserved, forwarded as-is)
//  mem_rd_en           out  1       membrane memory read strobe
//  mem_rd_addr         out  ADDR_W  read address
//  mem_rd_data         in   DATA_W  read data, valid exactly 1 cycle after mem_rd_en
//  dec_req_valid       out  1       request to decay unit
//  dec_req_ready       in   1       decay unit accepts request
//  dec_potential       out  DATA_W  potential to decay
//  dec_rate            out  4       sanitised decay rate
//  dec_model           out  2       model select
//  dec_rsp_valid       in   1       decay result valid (>=1 cycle after accept)
//  dec_rsp_potential   in   DATA_W  decayed potential
//  mem_wr_en           out  1       write-back strobe
//  mem_wr_addr         out  ADDR_W  write-back address
//  mem_wr_data         out  DATA_W  write-back data
//  busy                out  1       sweep in progress (state != IDLE)
//  done                out  1       1-cycle pulse, sweep complete
//  overrun             out  1       1-cycle pulse, timestep_start arrived while busy
// BEHAVIOUR
//  Reset: state IDLE, idx=0, every output 0, config table = {rate 0001, model 00} for all neurons.
//  States and transitions:
//   IDLE -> READ on timestep_start.
//   READ: mem_rd_en=1, mem_rd_addr=idx -> WAIT_RD.
//   WAIT_RD: latch mem_rd_data -> ISSUE.
//   ISSUE: dec_req_valid=1, payload stable until dec_req_valid&&dec_req_ready -> WAIT_RSP.
//   WAIT_RSP: on dec_rsp_valid latch result -> WRITE.
//   WRITE: mem_wr_en=1, addr=idx, data=latched result.
//     If idx==NUM_NEURONS-1 -> DONE, else idx+1 -> READ.
//   DONE: done=1 for one cycle, idx=0 -> IDLE.
//  Latency: start sampled at cycle 0; with ready=1 and rsp one cycle after accept, 5 cycles/neuron;
//   done in cycle 1+5*NUM_NEURONS (101 for default).
//  dec_rate/dec_model are sampled from the table in WAIT_RD (table read is combinational).
//   A cfg write to neuron k mid-sweep takes effect this sweep only if k has not yet reached WAIT_RD.
//  Rate sanitising: any value outside {0001,0010,0100,1000,0011} is issued as 0001.
//  cfg_addr >= NUM_NEURONS: write ignored.
//  timestep_start while busy (including DONE): ignored; overrun=1 in the following cycle.
//  dec_rsp_valid outside WAIT_RSP: ignored. dec_req_valid never deasserts before handshake.
//  rst mid-sweep: next cycle IDLE; no further mem write; partially swept neurons stay as written.
//  idx width ADDR_W; no wrap beyond NUM_NEURONS-1.
// STRUCTURE
//  Package snn_decay_pkg:
//   - rate encodings RATE_DIV1/2/4/8/RATE_DIV2P4
//   - model encodings MODEL_LIF/IZHI/QLIF
//   - state enum
//   - function sanitize_rate()
//  Sub-module decay_config_table:
//   - NUM_NEURONS x 6-bit register file
//   - synchronous write, async read, synchronous reset to {0001,00}
//  Scheduler FSM and data latches stay in this module.
// TESTING
//  1. Mem[0]=0x41DED852, rate 0010, bench decay model = exponent-1; one start
//     -> mem_wr_data 0x415ED852 at addr 0; done at cycle 101.
//  2. Hold dec_req_ready=0 for 7 cycles on neuron 3
//     -> dec_req_valid and dec_potential stable throughout; done delayed by exactly 7 cycles.
//  3. cfg rate 0101 on neuron 5
//     -> dec_rate=0001 for neuron 5; cfg_addr=20 write -> table unchanged.
//  4. Second timestep_start at cycle 50
//     -> overrun pulse at cycle 51; sweep finishes normally; one done only.
//  5. rst asserted during WAIT_RSP of neuron 10
//     -> IDLE next cycle; no mem_wr_en for idx 10; new start resweeps from idx 0.
//  6. Write neuron 15 rate 1000 at cycle 30 of a sweep
//     -> dec_rate=1000 for neuron 15 in that same sweep.

Source files
------------

// File: rtl/snn_decay_pkg.sv
// Shared encodings, FSM state type and rate sanitising for the potential-decay scheduler.
package snn_decay_pkg;

  localparam logic [3:0] RATE_DIV1   = 4'b0001;
  localparam logic [3:0] RATE_DIV2   = 4'b0010;
  localparam logic [3:0] RATE_DIV4   = 4'b0100;
  localparam logic [3:0] RATE_DIV8   = 4'b1000;
  localparam logic [3:0] RATE_DIV2P4 = 4'b0011;

  localparam logic [1:0] MODEL_LIF  = 2'b00;
  localparam logic [1:0] MODEL_IZHI = 2'b01;
  localparam logic [1:0] MODEL_QLIF = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT_RD,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [3:0] rate;
    logic [1:0] model;
  } cfg_entry_t;

  localparam cfg_entry_t CFG_RESET = '{rate: RATE_DIV1, model: MODEL_LIF};

  // Unsupported rate codes fall back to "no decay" rather than reaching the datapath.
  function automatic logic [3:0] sanitize_rate(input logic [3:0] rate);
    case (rate)
      RATE_DIV1, RATE_DIV2, RATE_DIV4, RATE_DIV8, RATE_DIV2P4: sanitize_rate = rate;
      default:                                                 sanitize_rate = RATE_DIV1;
    endcase
  endfunction

endpackage

// File: rtl/decay_config_table.sv
// Per-neuron decay rate / model register file: synchronous write, combinational read.
module decay_config_table
  import snn_decay_pkg::*;
#(
  parameter int NUM_NEURONS = 20,
  parameter int IDX_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [3:0]       wr_rate,
  input  logic [1:0]       wr_model,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [3:0]       rd_rate,
  output logic [1:0]       rd_model
);

  cfg_entry_t entries_q [NUM_NEURONS];

  // NOTE: this is a register file, not a RAM macro, so every entry is reset to {DIV1, LIF}.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        entries_q[i] <= CFG_RESET;
      end
    end else if (we) begin
      entries_q[wr_addr] <= '{rate: wr_rate, model: wr_model};
    end
  end

  assign rd_rate  = entries_q[rd_addr].rate;
  assign rd_model = entries_q[rd_addr].model;

endmodule

// File: rtl/neuron_decay_scheduler.sv
// Per-timestep sweep sequencer: read potential, issue to the shared decay unit, collect, write back.
module neuron_decay_scheduler
  import snn_decay_pkg::*;
#(
  parameter int NUM_NEURONS = 20,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              timestep_start,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [3:0]        cfg_decay_rate,
  input  logic [1:0]        cfg_model,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dec_req_valid,
  input  logic              dec_req_ready,
  output logic [DATA_W-1:0] dec_potential,
  output logic [3:0]        dec_rate,
  output logic [1:0]        dec_model,
  input  logic              dec_rsp_valid,
  input  logic [DATA_W-1:0] dec_rsp_potential,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int                IDX_W    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [ADDR_W:0]   NUM_EXT  = (ADDR_W + 1)'(NUM_NEURONS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   pot_q;
  logic [DATA_W-1:0]   rsp_q;
  logic [3:0]          rate_q;
  logic [1:0]          model_q;
  logic                overrun_q;
  logic [3:0]          tbl_rate;
  logic [1:0]          tbl_model;
  logic                cfg_hit;

  // Out-of-range neuron addresses must never alias onto a real table entry.
  assign cfg_hit = cfg_we && ({1'b0, cfg_addr} < NUM_EXT);

  decay_config_table #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W)
  ) u_cfg (
    .clk      (clk),
    .rst      (rst),
    .we       (cfg_hit),
    .wr_addr  (cfg_addr[IDX_W-1:0]),
    .wr_rate  (cfg_decay_rate),
    .wr_model (cfg_model),
    .rd_addr  (idx_q[IDX_W-1:0]),
    .rd_rate  (tbl_rate),
    .rd_model (tbl_model)
  );

  // NOTE: all clocked state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    mem_rd_en     = 1'b0;
    dec_req_valid = 1'b0;
    mem_wr_en     = 1'b0;
    done          = 1'b0;
    case (state_q)
      ST_IDLE:     if (timestep_start) state_d = ST_READ;
      ST_READ: begin
        mem_rd_en = 1'b1;
        state_d   = ST_WAIT_RD;
      end
      ST_WAIT_RD:  state_d = ST_ISSUE;
      ST_ISSUE: begin
        dec_req_valid = 1'b1;
        if (dec_req_ready) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: if (dec_rsp_valid) state_d = ST_WRITE;
      ST_WRITE: begin
        mem_wr_en = 1'b1;
        state_d   = (idx_q == LAST_IDX) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      pot_q     <= '0;
      rsp_q     <= '0;
      rate_q    <= '0;
      model_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= timestep_start && (state_q != ST_IDLE);
      case (state_q)
        // Config is captured here, so later table writes cannot disturb an in-flight request.
        ST_WAIT_RD: begin
          pot_q   <= mem_rd_data;
          rate_q  <= sanitize_rate(tbl_rate);
          model_q <= tbl_model;
        end
        ST_WAIT_RSP: if (dec_rsp_valid) rsp_q <= dec_rsp_potential;
        ST_WRITE:    if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        ST_DONE:     idx_q <= '0;
        default:     ;
      endcase
    end
  end

  assign mem_rd_addr   = idx_q;
  assign mem_wr_addr   = idx_q;
  assign mem_wr_data   = rsp_q;
  assign dec_potential = pot_q;
  assign dec_rate      = rate_q;
  assign dec_model     = model_q;
  assign busy          = (state_q != ST_IDLE);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_neuron_decay_scheduler.sv
// Scoreboard bench: membrane memory and decay unit models, queued request / write-back expectations.
module tb_neuron_decay_scheduler;

  localparam int N = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        timestep_start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [11:0] cfg_addr = '0;
  logic [3:0]  cfg_decay_rate = '0;
  logic [1:0]  cfg_model = '0;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic        dec_req_valid;
  logic        dec_req_ready = 1'b1;
  logic [31:0] dec_potential;
  logic [3:0]  dec_rate;
  logic [1:0]  dec_model;
  logic        dec_rsp_valid = 1'b0;
  logic [31:0] dec_rsp_potential = '0;
  logic        mem_wr_en;
  logic [11:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        busy;
  logic        done;
  logic        overrun;

  neuron_decay_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .timestep_start    (timestep_start),
    .cfg_we            (cfg_we),
    .cfg_addr          (cfg_addr),
    .cfg_decay_rate    (cfg_decay_rate),
    .cfg_model         (cfg_model),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_data       (mem_rd_data),
    .dec_req_valid     (dec_req_valid),
    .dec_req_ready     (dec_req_ready),
    .dec_potential     (dec_potential),
    .dec_rate          (dec_rate),
    .dec_model         (dec_model),
    .dec_rsp_valid     (dec_rsp_valid),
    .dec_rsp_potential (dec_rsp_potential),
    .mem_wr_en         (mem_wr_en),
    .mem_wr_addr       (mem_wr_addr),
    .mem_wr_data       (mem_wr_data),
    .busy              (busy),
    .done              (done),
    .overrun           (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] pot;
    logic [3:0]  rate;
    logic [1:0]  model;
    logic [31:0] res;
  } exp_t;

  exp_t        req_q [$];
  exp_t        wr_q  [$];
  logic [31:0] mem     [4096];
  logic [31:0] exp_mem [4096];
  logic [3:0]  g_rate  [N];
  logic [1:0]  g_model [N];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int sweep_s = 0;
  int done_cnt = 0, done_rel = -1, ovr_cnt = 0, ovr_rel = -1;
  int stall_addr = -1, stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_rate(input logic [3:0] r);
    case (r)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011: return r;
      default: return 4'b0001;
    endcase
  endfunction

  // Stand-in decay unit: exponent shift for /2,/4,/8, truncated 0.75x for /2+/4.
  function automatic logic [31:0] bench_decay(input logic [31:0] x, input logic [3:0] rate);
    logic [7:0]  e;
    logic [25:0] v;
    e = x[30:23];
    case (rate)
      4'b0010: return {x[31], e - 8'd1, x[22:0]};
      4'b0100: return {x[31], e - 8'd2, x[22:0]};
      4'b1000: return {x[31], e - 8'd3, x[22:0]};
      4'b0011: begin
        v = 26'({1'b1, x[22:0]}) * 26'd3;
        if (v[25]) return {x[31], e, v[24:2]};
        else       return {x[31], e - 8'd1, v[23:1]};
      end
      default: return x;
    endcase
  endfunction

  // Memory, decay unit and monitor, all acting on the falling edge.
  initial begin : models
    logic        rd_pend;
    logic [11:0] rd_addr_q;
    logic        rsp_pend;
    logic [31:0] rsp_data;
    logic        hs;
    logic        req_open;
    exp_t        e;
    rd_pend = 1'b0; rd_addr_q = '0; rsp_pend = 1'b0; rsp_data = '0; req_open = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_wr_en) begin
        mem[mem_wr_addr] = mem_wr_data;
        if (wr_q.size() == 0) begin
          check("wr_unexpected_addr", 32'(mem_wr_addr), 32'hFFFF_FFFF);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
          check("wr_data", mem_wr_data, e.res);
          exp_mem[e.addr] = e.res;
        end
      end

      if (dec_req_valid && stall_left > 0 && int'(mem_rd_addr) == stall_addr) begin
        dec_req_ready = 1'b0;
        stall_left--;
      end else begin
        dec_req_ready = 1'b1;
      end

      hs = 1'b0;
      if (req_open) check("req_hold_valid", 32'(dec_req_valid), 32'd1);
      if (dec_req_valid) begin
        if (req_q.size() == 0) begin
          check("req_unexpected_idx", 32'(mem_rd_addr), 32'hFFFF_FFFF);
        end else begin
          e = req_q[0];
          check("req_potential", dec_potential, e.pot);
          check("req_rate", 32'(dec_rate), 32'(e.rate));
          check("req_model", 32'(dec_model), 32'(e.model));
          if (dec_req_ready) begin
            void'(req_q.pop_front());
            hs = 1'b1;
          end
        end
      end
      req_open = dec_req_valid && !dec_req_ready;

      if (rsp_pend) begin
        dec_rsp_valid     = 1'b1;
        dec_rsp_potential = rsp_data;
      end else begin
        dec_rsp_valid     = (cyc % 3 == 0);
        dec_rsp_potential = 32'hBAD0_0000 | 32'(cyc);
      end
      rsp_pend = hs;
      if (hs) rsp_data = bench_decay(dec_potential, dec_rate);

      mem_rd_data = rd_pend ? mem[rd_addr_q] : 32'hDEAD_BEEF;
      rd_pend     = mem_rd_en;
      rd_addr_q   = mem_rd_addr;

      if (done) begin
        done_cnt++;
        done_rel = cyc - sweep_s;
      end
      if (overrun) begin
        ovr_cnt++;
        ovr_rel = cyc - sweep_s;
      end
    end
  end

  task automatic cfg_set(input logic [11:0] a, input logic [3:0] r, input logic [1:0] m);
    cfg_we = 1'b1; cfg_addr = a; cfg_decay_rate = r; cfg_model = m;
    if (int'(a) < N) begin
      g_rate[int'(a)]  = r;
      g_model[int'(a)] = m;
      foreach (req_q[j]) if (req_q[j].addr == int'(a)) begin
        req_q[j].rate  = exp_rate(r);
        req_q[j].model = m;
      end
      foreach (wr_q[j]) if (wr_q[j].addr == int'(a)) wr_q[j].res = bench_decay(wr_q[j].pot, exp_rate(r));
    end
  endtask

  task automatic cfg_write(input logic [11:0] a, input logic [3:0] r, input logic [1:0] m);
    @(negedge clk);
    cfg_set(a, r, m);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One sweep; cfg_at/restart_at/rst_at are cycles after the start pulse (-1 = unused).
  task automatic sweep(input int exp_lat, input int cfg_at, input int restart_at, input int rst_at);
    int   last;
    exp_t e;
    last = (rst_at >= 0) ? rst_at + 6 : exp_lat + 4;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      e.addr  = i;
      e.pot   = exp_mem[i];
      e.rate  = exp_rate(g_rate[i]);
      e.model = g_model[i];
      e.res   = bench_decay(e.pot, e.rate);
      req_q.push_back(e);
      wr_q.push_back(e);
    end
    done_cnt = 0; ovr_cnt = 0; done_rel = -1; ovr_rel = -1;
    sweep_s = cyc;
    timestep_start = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      timestep_start = (k == restart_at);
      cfg_we = 1'b0;
      if (k == cfg_at) cfg_set(12'd15, 4'b1000, 2'b00);
      if (k == rst_at) begin
        rst = 1'b1;
        req_q.delete();
        wr_q.delete();
        for (int i = 0; i < N; i++) begin
          g_rate[i]  = 4'b0001;
          g_model[i] = 2'b00;
        end
      end else if (rst) begin
        rst = 1'b0;
        check("rst_mid_sweep_busy", 32'(busy), 32'd0);
      end
    end
    check("done_count", 32'(done_cnt), (rst_at >= 0) ? 32'd0 : 32'd1);
    if (rst_at < 0) check("done_cycle", 32'(done_rel), 32'(exp_lat));
    check("overrun_count", 32'(ovr_cnt), (restart_at >= 0) ? 32'd1 : 32'd0);
    if (restart_at >= 0) check("overrun_cycle", 32'(ovr_rel), 32'(restart_at + 1));
    check("req_left", 32'(req_q.size()), 32'd0);
    check("wr_left", 32'(wr_q.size()), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    for (int i = 0; i < N; i++) begin
      mem[i]     = {1'b0, 8'h80 + 8'(i), 23'(i * 12345 + 32'h1234)};
      g_rate[i]  = 4'b0001;
      g_model[i] = 2'b00;
    end
    mem[0] = 32'h41DE_D852;
    for (int i = 0; i < N; i++) exp_mem[i] = mem[i];

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("reset_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("reset_dec_req_valid", 32'(dec_req_valid), 32'd0);
    check("reset_dec_rate", 32'(dec_rate), 32'd0);
    check("reset_dec_model", 32'(dec_model), 32'd0);
    check("reset_dec_potential", dec_potential, 32'd0);
    check("reset_mem_wr_data", mem_wr_data, 32'd0);
    check("reset_mem_rd_addr", 32'(mem_rd_addr), 32'd0);

    // Sweep A: rate/model mix, illegal rate, out-of-range config addresses.
    cfg_write(12'd0,  4'b0010, 2'b00);
    cfg_write(12'd5,  4'b0101, 2'b00);
    cfg_write(12'd7,  4'b0011, 2'b00);
    cfg_write(12'd9,  4'b1000, 2'b01);
    cfg_write(12'd20, 4'b1000, 2'b10);
    cfg_write(12'd35, 4'b0100, 2'b11);
    sweep(101, -1, -1, -1);

    // Sweep B: 7-cycle ready stall on neuron 3, neuron 15 reconfigured mid-sweep, early restart.
    stall_addr = 3;
    stall_left = 7;
    sweep(108, 30, 50, -1);
    check("stall_consumed", 32'(stall_left), 32'd0);

    // Sweep C: reset during WAIT_RSP of neuron 10.
    sweep(0, -1, -1, 54);

    // Sweep D: fresh sweep from neuron 0 with reset configuration.
    sweep(101, -1, -1, -1);

    for (int i = 0; i < N; i++) check("mem_final", mem[i], exp_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
